// File: rtl/seg7_display_mux_if.sv
// Processor-side write bus for the 7-segment display controller.
// Carries one 8-bit write per cycle: BUS_ADDR selects the register, BUS_DATA
// is the payload, BUS_WE qualifies the transfer; no backpressure.
interface seg7_display_mux_if;
   logic [7:0] BUS_DATA;
   logic [7:0] BUS_ADDR;
   logic       BUS_WE;

   // CPU / bench side drives the bus
   modport master (output BUS_DATA, BUS_ADDR, BUS_WE);
   // display controller samples it
   modport slave  (input  BUS_DATA, BUS_ADDR, BUS_WE);
endinterface

// File: rtl/seg7_display_mux.sv
// Multiplexed NUM_DIGITS-digit 7-segment controller with shadowed digit/dot/blank
// banks and 16-level per-slot PWM brightness.
// Latency: register writes land on the write edge; pins lag d/pwm/bank state by 1 cycle.
// Backpressure: none, every write is accepted in its cycle.
// Ports: CLK, RESETN (sync, active-low); bus (slave modport: BUS_DATA/BUS_ADDR/BUS_WE);
//        DISP_SEL_OUT (anode enables, one-hot or none); DISP_OUT ([6:0]=g..a, [7]=dp).
// Optional macro SEG7_LEADING_ZERO_BLANK_EN: auto-blank leading zero digits (digit 0 never).
module seg7_display_mux #(
   parameter int         NUM_DIGITS  = 4,
   parameter logic [7:0] BASE_ADDR   = 8'hD0,
   parameter int         CLK_FREQ_HZ = 100000000,
   parameter int         REFRESH_HZ  = 1000,
   parameter int         ACTIVE_LOW  = 1
) (
   input  logic                  CLK,
   input  logic                  RESETN,
   seg7_display_mux_if.slave     bus,
   output logic [NUM_DIGITS-1:0] DISP_SEL_OUT,
   output logic [7:0]            DISP_OUT
);

   localparam int H  = NUM_DIGITS / 2;
   localparam int P  = CLK_FREQ_HZ / (REFRESH_HZ * 16);
   localparam int PW = (P > 1) ? $clog2(P) : 1;
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [7:0] OFF_DOT    = 8'(H);
   localparam logic [7:0] OFF_BLANK  = 8'(H + 1);
   localparam logic [7:0] OFF_CTRL   = 8'(H + 2);
   localparam logic [7:0] OFF_COMMIT = 8'(H + 3);

   localparam logic [PW-1:0] PRESC_LAST = PW'(P - 1);
   localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);
   localparam logic          POL        = (ACTIVE_LOW != 0);

   if ((NUM_DIGITS % 2) != 0 || NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seg7_display_mux: NUM_DIGITS must be even and within 2..8");
   end
   if (P < 1) begin : g_bad_prescale
      $error("seg7_display_mux: CLK_FREQ_HZ / (REFRESH_HZ*16) must be at least 1");
   end

   // ---------------- state ----------------
   logic [PW-1:0]           presc_q, presc_d;
   logic [3:0]              pwm_q, pwm_d;
   logic [DW-1:0]           dig_q, dig_d;
   logic [NUM_DIGITS*4-1:0] sh_nib_q, sh_nib_d, act_nib_q, act_nib_d;
   logic [NUM_DIGITS-1:0]   sh_dot_q, sh_dot_d, act_dot_q, act_dot_d;
   logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
   logic                    en_q, en_d, auto_q, auto_d, pending_q, pending_d;
   logic [3:0]              bright_q, bright_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d;
   logic [7:0]              seg_q, seg_d;

   logic [7:0]              off;
   logic                    tick, boundary;
   logic [NUM_DIGITS-1:0]   lzb;
   logic                    above_ok;
   logic [3:0]              cur_nib;
   logic                    cur_dot, cur_blank, cur_lzb, lit;
   logic [NUM_DIGITS-1:0]   onehot;

   // Register offset relative to BASE_ADDR; 8-bit wrap keeps the map contiguous.
   assign off = bus.BUS_ADDR - BASE_ADDR;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   // ---------------- timing chain, registers, bank copy ----------------
   always_comb begin
      presc_d     = presc_q;
      pwm_d       = pwm_q;
      dig_d       = dig_q;
      sh_nib_d    = sh_nib_q;
      sh_dot_d    = sh_dot_q;
      sh_blank_d  = sh_blank_q;
      act_nib_d   = act_nib_q;
      act_dot_d   = act_dot_q;
      act_blank_d = act_blank_q;
      en_d        = en_q;
      auto_d      = auto_q;
      bright_d    = bright_q;
      pending_d   = pending_q;

      tick     = (presc_q == PRESC_LAST);
      boundary = tick && (pwm_q == 4'hF) && (dig_q == DIG_LAST);

      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
         pwm_d = pwm_q + 4'd1;
         if (pwm_q == 4'hF) begin
            dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
         end
      end

      // Copy uses the pre-edge shadow, so a same-cycle shadow write misses it.
      if (boundary && (pending_q || auto_q)) begin
         act_nib_d   = sh_nib_q;
         act_dot_d   = sh_dot_q;
         act_blank_d = sh_blank_q;
         pending_d   = 1'b0;
      end

      if (bus.BUS_WE) begin
         for (int k = 0; k < H; k++) begin
            if (off == 8'(k)) sh_nib_d[k*8 +: 8] = bus.BUS_DATA;
         end
         if (off == OFF_DOT)   sh_dot_d   = bus.BUS_DATA[NUM_DIGITS-1:0];
         if (off == OFF_BLANK) sh_blank_d = bus.BUS_DATA[NUM_DIGITS-1:0];
         if (off == OFF_CTRL) begin
            en_d     = bus.BUS_DATA[0];
            auto_d   = bus.BUS_DATA[1];
            bright_d = bus.BUS_DATA[7:4];
         end
         // Placed after the copy so a COMMIT on the boundary survives to the next frame.
         if (off == OFF_COMMIT) pending_d = 1'b1;
      end
   end

   // ---------------- leading-zero suppression ----------------
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // Walk from the top digit down: a zero is suppressed while everything above
   // it is zero or blanked. Digit 0 is left alone.
   always_comb begin
      lzb      = '0;
      above_ok = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         lzb[i]   = above_ok && (act_nib_q[i*4 +: 4] == 4'h0);
         above_ok = above_ok && ((act_nib_q[i*4 +: 4] == 4'h0) || act_blank_q[i]);
      end
   end
`else
   always_comb begin
      lzb      = '0;
      above_ok = 1'b0;
   end
`endif

   // ---------------- output decode ----------------
   always_comb begin
      cur_nib   = 4'h0;
      cur_dot   = 1'b0;
      cur_blank = 1'b0;
      cur_lzb   = 1'b0;
      onehot    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (dig_q == DW'(i)) begin
            cur_nib   = act_nib_q[i*4 +: 4];
            cur_dot   = act_dot_q[i];
            cur_blank = act_blank_q[i];
            cur_lzb   = lzb[i];
            onehot[i] = 1'b1;
         end
      end
      lit   = en_q && !cur_blank && !cur_lzb && (pwm_q <= bright_q) && !above_ok_unused();
      sel_d = (lit ? onehot : '0) ^ {NUM_DIGITS{POL}};
      seg_d = (lit ? {cur_dot, hex7(cur_nib)} : 8'h00) ^ {8{POL}};
   end

   // above_ok is only meaningful inside the suppression walk; this keeps it referenced.
   function automatic logic above_ok_unused();
      return 1'b0 & above_ok;
   endfunction

   // ---------------- state register ----------------
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         presc_q     <= '0;
         pwm_q       <= '0;
         dig_q       <= '0;
         sh_nib_q    <= '0;
         sh_dot_q    <= '0;
         sh_blank_q  <= '0;
         act_nib_q   <= '0;
         act_dot_q   <= '0;
         act_blank_q <= '0;
         en_q        <= 1'b0;
         auto_q      <= 1'b0;
         bright_q    <= 4'hF;
         pending_q   <= 1'b0;
         sel_q       <= {NUM_DIGITS{POL}};
         seg_q       <= {8{POL}};
      end else begin
         presc_q     <= presc_d;
         pwm_q       <= pwm_d;
         dig_q       <= dig_d;
         sh_nib_q    <= sh_nib_d;
         sh_dot_q    <= sh_dot_d;
         sh_blank_q  <= sh_blank_d;
         act_nib_q   <= act_nib_d;
         act_dot_q   <= act_dot_d;
         act_blank_q <= act_blank_d;
         en_q        <= en_d;
         auto_q      <= auto_d;
         bright_q    <= bright_d;
         pending_q   <= pending_d;
         sel_q       <= sel_d;
         seg_q       <= seg_d;
      end
   end

   assign DISP_SEL_OUT = sel_q;
   assign DISP_OUT     = seg_q;

endmodule
